temp_sensor_master_multi: RTL and testbench

Parametrised multi-channel serial temperature-sensor master, generalised from the single-sensor LM07 reader.
- Polls NCH sensors round-robin over a shared sclk/sio bus, each with its own active-low chip select.
- Extracts the signed temperature field and converts it to integer degrees.
- Keeps per-channel results with a hysteresis over-temperature alarm, and drives a sign/tens/units 7-segment display for a selected channel.

---
 rtl/temp_sensor_pkg.sv | 43 ++++
 rtl/temp_seg_decoder.sv | 30 +++
 rtl/temp_sensor_master_multi.sv | 197 +++++++++++++++++++
 tb/tb_temp_sensor_master_multi.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/temp_sensor_pkg.sv
// rtl/temp_sensor_pkg.sv - shared FSM encoding and 7-segment glyphs for the temperature-sensor master
package temp_sensor_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_SHIFT  = 3'd2,
        ST_HOLD   = 3'd3,
        ST_UPDATE = 3'd4,
        ST_GAP    = 3'd5
    } state_t;

    // Segment order {a,b,c,d,e,f,g}, bit6 = a, active high
    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_MINUS = 7'b0000001;

    function automatic logic [6:0] seg_digit(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/temp_seg_decoder.sv
// rtl/temp_seg_decoder.sv - signed integer degrees to sign/tens/units 7-segment glyphs
// Ports: i_temp (signed 8-bit C) -> o_seg_sign, o_seg_tens, o_seg_units (combinational)
module temp_seg_decoder
    import temp_sensor_pkg::*;
(
    input  logic [7:0] i_temp,
    output logic [6:0] o_seg_sign,
    output logic [6:0] o_seg_tens,
    output logic [6:0] o_seg_units
);

    logic [7:0] w_mag;
    logic [3:0] w_tens;
    logic [3:0] w_units;

    always_comb begin
        // -(-128) wraps to 8'h80 = 128 unsigned, which the clamp below handles
        w_mag = i_temp[7] ? (8'd0 - i_temp) : i_temp;
        if (w_mag > 8'd99) begin
            w_mag = 8'd99;
        end
        w_tens  = 4'(w_mag / 8'd10);
        w_units = 4'(w_mag % 8'd10);

        o_seg_sign  = i_temp[7] ? SEG_MINUS : SEG_BLANK;
        o_seg_tens  = (w_tens == 4'd0) ? SEG_BLANK : seg_digit(w_tens);
        o_seg_units = seg_digit(w_units);
    end

endmodule

// File: rtl/temp_sensor_master_multi.sv
// rtl/temp_sensor_master_multi.sv - round-robin multi-channel serial temperature sensor master
// Ports: clk, reset (sync, active low), enable, sio in; sclk, cs_n[NCH], busy out;
//        disp_sel in; sample_valid/sample_ch/sample_temp, alarm[NCH], seg_sign/tens/units out
module temp_sensor_master_multi
    import temp_sensor_pkg::*;
#(
    parameter int NCH         = 4,
    parameter int FRAME_BITS  = 16,
    parameter int TEMP_BITS   = 10,
    parameter int FRAC_BITS   = 2,
    parameter int CLK_DIV     = 4,
    parameter int IDLE_CYCLES = 64,
    parameter int HI_THRESH   = 50,
    parameter int HYST        = 2,
    localparam int CHW        = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           enable,
    input  logic           sio,
    output logic           sclk,
    output logic [NCH-1:0] cs_n,
    output logic           busy,
    input  logic [CHW-1:0] disp_sel,
    output logic           sample_valid,
    output logic [CHW-1:0] sample_ch,
    output logic [7:0]     sample_temp,
    output logic [NCH-1:0] alarm,
    output logic [6:0]     seg_sign,
    output logic [6:0]     seg_tens,
    output logic [6:0]     seg_units
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HW = $clog2(2 * FRAME_BITS);
    localparam int IW = $clog2(IDLE_CYCLES + 1);

    state_t                r_state;
    logic [CHW-1:0]        r_ch;
    logic [DW-1:0]         r_div;
    logic [HW-1:0]         r_half;
    logic [IW-1:0]         r_idle_cnt;
    logic                  r_first;
    logic                  r_sclk;
    logic [FRAME_BITS-1:0] r_shreg;
    logic [CHW-1:0]        r_sample_ch;
    logic [7:0]            r_sample_temp;
    logic [NCH-1:0]        r_alarm;
    logic [7:0]            r_temp [NCH];

    logic                        w_div_end;
    logic                        w_last_half;
    logic                        w_last_ch;
    logic                        w_idle_done;
    logic signed [TEMP_BITS-1:0] w_raw;
    int                          w_deg_full;
    logic [7:0]                  w_deg;
    logic                        w_alarm_next;
    logic [7:0]                  w_disp_temp;

    assign w_div_end   = (r_div == DW'(CLK_DIV - 1));
    assign w_last_half = (r_half == HW'(2 * FRAME_BITS - 1));
    assign w_last_ch   = (r_ch == CHW'(NCH - 1));
    // The very first round after reset skips the idle wait
    assign w_idle_done = r_first || (r_idle_cnt == IW'(IDLE_CYCLES - 1));

    always_comb begin
        w_raw      = r_shreg[FRAME_BITS-1 -: TEMP_BITS];
        w_deg_full = int'(w_raw) >>> FRAC_BITS;
        if (w_deg_full > 127) begin
            w_deg = 8'd127;
        end else if (w_deg_full < -128) begin
            w_deg = 8'h80;
        end else begin
            w_deg = w_deg_full[7:0];
        end

        w_alarm_next = r_alarm[r_ch];
        if (w_deg_full >= HI_THRESH) begin
            w_alarm_next = 1'b1;
        end else if (w_deg_full < HI_THRESH - HYST) begin
            w_alarm_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_ch          <= '0;
            r_div         <= '0;
            r_half        <= '0;
            r_idle_cnt    <= '0;
            r_first       <= 1'b1;
            r_sclk        <= 1'b0;
            r_shreg       <= '0;
            r_sample_ch   <= '0;
            r_sample_temp <= '0;
            r_alarm       <= '0;
            for (int i = 0; i < NCH; i++) begin
                r_temp[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_idle_done) begin
                        r_idle_cnt <= r_idle_cnt + 1'b1;
                    end else if (enable) begin
                        r_state <= ST_SETUP;
                        r_first <= 1'b0;
                        r_div   <= '0;
                    end
                end
                ST_SETUP: begin
                    r_div <= r_div + 1'b1;
                    if (w_div_end) begin
                        // This edge raises sclk for the first time, so it captures the MSB
                        r_div   <= '0;
                        r_half  <= '0;
                        r_sclk  <= 1'b1;
                        r_shreg <= {r_shreg[FRAME_BITS-2:0], sio};
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_div <= r_div + 1'b1;
                    if (w_div_end) begin
                        r_div <= '0;
                        if (w_last_half) begin
                            // Final half-period is already low; leave sclk there
                            r_state <= ST_HOLD;
                        end else begin
                            r_half <= r_half + 1'b1;
                            r_sclk <= ~r_sclk;
                            if (!r_sclk) begin
                                r_shreg <= {r_shreg[FRAME_BITS-2:0], sio};
                            end
                        end
                    end
                end
                ST_HOLD: begin
                    r_div <= r_div + 1'b1;
                    if (w_div_end) begin
                        // Results land on the edge entering UPDATE so they are visible with the pulse
                        r_div          <= '0;
                        r_state        <= ST_UPDATE;
                        r_sample_ch    <= r_ch;
                        r_sample_temp  <= w_deg;
                        r_temp[r_ch]   <= w_deg;
                        r_alarm[r_ch]  <= w_alarm_next;
                    end
                end
                ST_UPDATE: begin
                    if (w_last_ch || !enable) begin
                        r_state    <= ST_IDLE;
                        r_ch       <= '0;
                        r_idle_cnt <= '0;
                    end else begin
                        r_state <= ST_GAP;
                        r_div   <= '0;
                    end
                end
                ST_GAP: begin
                    r_div <= r_div + 1'b1;
                    if (w_div_end) begin
                        r_div   <= '0;
                        r_ch    <= r_ch + 1'b1;
                        r_state <= ST_SETUP;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        cs_n = '1;
        if (r_state == ST_SETUP || r_state == ST_SHIFT || r_state == ST_HOLD) begin
            cs_n[r_ch] = 1'b0;
        end
    end

    assign busy         = ~&cs_n;
    assign sclk         = r_sclk;
    assign sample_valid = (r_state == ST_UPDATE);
    assign sample_ch    = r_sample_ch;
    assign sample_temp  = r_sample_temp;
    assign alarm        = r_alarm;
    assign w_disp_temp  = (int'(disp_sel) < NCH) ? r_temp[disp_sel] : r_temp[0];

    temp_seg_decoder u_seg (
        .i_temp      (w_disp_temp),
        .o_seg_sign  (seg_sign),
        .o_seg_tens  (seg_tens),
        .o_seg_units (seg_units)
    );

endmodule

// File: tb/tb_temp_sensor_master_multi.sv
// tb/tb_temp_sensor_master_multi.sv - self-checking bench for temp_sensor_master_multi
module tb_temp_sensor_master_multi;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       sio;
    logic       sclk;
    logic [3:0] cs_n;
    logic       busy;
    logic [1:0] disp_sel;
    logic       sample_valid;
    logic [1:0] sample_ch;
    logic [7:0] sample_temp;
    logic [3:0] alarm;
    logic [6:0] seg_sign;
    logic [6:0] seg_tens;
    logic [6:0] seg_units;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int rises = 0;
    int t_fall = 0;
    int rises_at_fall = 0;

    logic [15:0] sens_frame [4];
    int          fall_cnt = 0;
    logic        s_prev = 1'b0;

    int   m_temp [4];
    logic [3:0] m_alarm;

    temp_sensor_master_multi dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .sio          (sio),
        .sclk         (sclk),
        .cs_n         (cs_n),
        .busy         (busy),
        .disp_sel     (disp_sel),
        .sample_valid (sample_valid),
        .sample_ch    (sample_ch),
        .sample_temp  (sample_temp),
        .alarm        (alarm),
        .seg_sign     (seg_sign),
        .seg_tens     (seg_tens),
        .seg_units    (seg_units)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge sclk) rises <= rises + 1;

    // Sensor: MSB presented when its chip select falls, next bit after each sclk fall
    always @(cs_n or sclk) begin
        if (cs_n == 4'hF) fall_cnt = 0;
        else if (s_prev && !sclk) fall_cnt++;
        s_prev = sclk;
        sio = 1'b0;
        for (int i = 0; i < 4; i++)
            if (cs_n[i] === 1'b0 && fall_cnt < 16) sio = sens_frame[i][15 - fall_cnt];
    end

    function automatic int m_deg(input logic [15:0] f);
        int raw, d;
        raw = int'(f[15:6]);
        if (raw >= 512) raw = raw - 1024;
        if (raw >= 0) d = raw / 4;
        else d = -((-raw + 3) / 4);
        if (d > 127) d = 127;
        if (d < -128) d = -128;
        return d;
    endfunction

    function automatic logic [6:0] glyph(input int d);
        case (d)
            0: return 7'b1111110;
            1: return 7'b0110000;
            2: return 7'b1101101;
            3: return 7'b1111001;
            4: return 7'b0110011;
            5: return 7'b1011011;
            6: return 7'b1011111;
            7: return 7'b1110000;
            8: return 7'b1111111;
            default: return 7'b1111011;
        endcase
    endfunction

    function automatic logic [20:0] m_disp(input int t);
        int mag;
        logic [6:0] s, te, u;
        mag = (t < 0) ? -t : t;
        if (mag > 99) mag = 99;
        s  = (t < 0) ? 7'b0000001 : 7'b0000000;
        te = (mag / 10 == 0) ? 7'b0000000 : glyph(mag / 10);
        u  = glyph(mag % 10);
        return {s, te, u};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cs(input int exp_ch);
        int k;
        k = 0;
        while (cs_n == 4'hF && k < 3000) begin
            @(posedge clk); #1;
            k++;
        end
        check("cs_seen", {31'd0, cs_n != 4'hF}, 32'd1);
        check("cs_order", {28'd0, cs_n}, {28'd0, ~(4'b0001 << exp_ch)});
        t_fall = cyc;
        rises_at_fall = rises;
    endtask

    task automatic finish_frame(input int exp_ch);
        int k, d;
        k = 0;
        while (!sample_valid && k < 400) begin
            @(posedge clk); #1;
            k++;
        end
        d = m_deg(sens_frame[exp_ch]);
        m_temp[exp_ch] = d;
        if (d >= 50) m_alarm[exp_ch] = 1'b1;
        else if (d < 48) m_alarm[exp_ch] = 1'b0;
        check("sv_seen", {31'd0, sample_valid}, 32'd1);
        check("sv_latency", 32'(cyc - t_fall), 32'd136);
        check("sclk_rises", 32'(rises - rises_at_fall), 32'd16);
        check("sample_ch", {30'd0, sample_ch}, 32'(exp_ch));
        check("sample_temp", {24'd0, sample_temp}, {24'd0, 8'(d)});
        check("alarm", {28'd0, alarm}, {28'd0, m_alarm});
        check("cs_high_update", {28'd0, cs_n}, 32'hF);
    endtask

    task automatic check_disp(input int sel);
        logic [20:0] e;
        disp_sel = 2'(sel);
        #1;
        e = m_disp(m_temp[sel]);
        check("seg_sign", {25'd0, seg_sign}, {25'd0, e[20:14]});
        check("seg_tens", {25'd0, seg_tens}, {25'd0, e[13:7]});
        check("seg_units", {25'd0, seg_units}, {25'd0, e[6:0]});
    endtask

    task automatic run_round(input logic [15:0] f0, input logic [15:0] f1,
                             input logic [15:0] f2, input logic [15:0] f3);
        sens_frame[0] = f0;
        sens_frame[1] = f1;
        sens_frame[2] = f2;
        sens_frame[3] = f3;
        for (int c = 0; c < 4; c++) begin
            wait_cs(c);
            finish_frame(c);
            check_disp(int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        int bad, t_en;
        reset    = 1'b0;
        enable   = 1'b1;
        disp_sel = 2'd0;
        m_alarm  = 4'd0;
        for (int i = 0; i < 4; i++) begin
            m_temp[i]     = 0;
            sens_frame[i] = 16'h1900;
        end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_cs_n", {28'd0, cs_n}, 32'hF);
        check("rst_sclk", {31'd0, sclk}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_sv", {31'd0, sample_valid}, 32'd0);
        check("rst_ch", {30'd0, sample_ch}, 32'd0);
        check("rst_temp", {24'd0, sample_temp}, 32'd0);
        check("rst_alarm", {28'd0, alarm}, 32'd0);
        check_disp(0);

        // Round 1: 25 C on all channels
        reset = 1'b1;
        run_round(16'h1900, 16'h1900, 16'h1900, 16'h1900);
        disp_sel = 2'd0;
        #1;
        check("r1_tens", {25'd0, seg_tens}, {25'd0, 7'b1101101});
        check("r1_units", {25'd0, seg_units}, {25'd0, 7'b1011011});
        check("r1_sign", {25'd0, seg_sign}, 32'd0);

        // Round 2: negative, alarm set, saturated display
        run_round(16'($urandom), 16'hF600, 16'h3700, 16'h7800);
        check("r2_alarm2", {31'd0, alarm[2]}, 32'd1);
        check("r2_alarm3", {31'd0, alarm[3]}, 32'd1);
        check_disp(1);
        check_disp(3);

        // Rounds 3 and 4: hysteresis hold then clear on ch2
        run_round(16'($urandom), 16'($urandom), 16'h3100, 16'($urandom));
        check("r3_alarm2", {31'd0, alarm[2]}, 32'd1);
        run_round(16'($urandom), 16'($urandom), 16'h2F00, 16'($urandom));
        check("r4_alarm2", {31'd0, alarm[2]}, 32'd0);

        // Random rounds
        for (int r = 0; r < 3; r++)
            run_round(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));

        // Drop enable during ch1 shift
        sens_frame[0] = 16'($urandom);
        sens_frame[1] = 16'($urandom);
        wait_cs(0);
        finish_frame(0);
        wait_cs(1);
        repeat (40) @(posedge clk);
        #1;
        enable = 1'b0;
        finish_frame(1);
        bad = 0;
        repeat (300) begin
            @(posedge clk); #1;
            if (cs_n != 4'hF || sample_valid) bad++;
        end
        check("disabled_quiet", 32'(bad), 32'd0);
        enable = 1'b1;
        t_en = cyc;
        wait_cs(0);
        check("restart_bound", {31'd0, (t_fall - t_en) <= 66}, 32'd1);
        finish_frame(0);
        check_disp(0);

        // Reset mid-shift of ch1
        sens_frame[1] = 16'($urandom);
        wait_cs(1);
        repeat (50) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) m_temp[i] = 0;
        m_alarm = 4'd0;
        check("mid_rst_cs_n", {28'd0, cs_n}, 32'hF);
        check("mid_rst_sclk", {31'd0, sclk}, 32'd0);
        check("mid_rst_sv", {31'd0, sample_valid}, 32'd0);
        check("mid_rst_alarm", {28'd0, alarm}, 32'd0);
        check_disp(1);
        repeat (3) @(posedge clk);
        #1;
        sens_frame[0] = 16'($urandom);
        reset = 1'b1;
        wait_cs(0);
        finish_frame(0);
        check_disp(0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
